demux8x8_deframer: RTL and testbench

- Receive-side counterpart of the 8-input, 8-bit word multiplexer.
- A counter-driven 8:1 mux time-division serializes eight 8-bit lanes onto one 8-bit stream. This block demultiplexes that stream back into eight parallel 8-bit lanes.
- Words are accepted over a valid/ready handshake, steered by an internal slot counter, and optionally realigned by a start-of-frame marker.
- Each completed 8-word frame is presented on a double-buffered parallel output with its own valid/ready handshake.

---
 rtl/demux8x8_deframer_if.sv | 38 +++
 rtl/demux8x8_deframer.sv | 81 ++++++++
 tb/tb_demux8x8_deframer.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/demux8x8_deframer_if.sv
// demux8x8_deframer_if
//   Bundles the serial input stream and the parallel frame output of the
//   8-lane deframer.
//   Serial side : i, i_valid, i_sync (in to block), i_ready (out of block)
//   Frame side  : o0..o7, o_valid (out of block), o_ready (in to block)
//   Status      : slot (next slot to be written), err (misalignment pulse)
//   Modport slave is the deframer; modport master is whoever drives the
//   stream and consumes frames.
interface demux8x8_deframer_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] i;
  logic             i_valid;
  logic             i_sync;
  logic             i_ready;
  logic [WIDTH-1:0] o0;
  logic [WIDTH-1:0] o1;
  logic [WIDTH-1:0] o2;
  logic [WIDTH-1:0] o3;
  logic [WIDTH-1:0] o4;
  logic [WIDTH-1:0] o5;
  logic [WIDTH-1:0] o6;
  logic [WIDTH-1:0] o7;
  logic             o_valid;
  logic             o_ready;
  logic [2:0]       slot;
  logic             err;

  modport slave (
    input  i, i_valid, i_sync, o_ready,
    output i_ready, o0, o1, o2, o3, o4, o5, o6, o7, o_valid, slot, err
  );

  modport master (
    output i, i_valid, i_sync, o_ready,
    input  i_ready, o0, o1, o2, o3, o4, o5, o6, o7, o_valid, slot, err
  );
endinterface

// File: rtl/demux8x8_deframer.sv
// demux8x8_deframer
//   Demultiplexes a time-division serialized stream of 8 words back into
//   eight parallel lanes. Words are steered into fill registers by a 3-bit
//   slot counter; the eighth word closes the frame and the whole frame is
//   copied into the output buffer together with that word. A start-of-frame
//   marker arriving at a nonzero slot restarts the frame at slot 0 and
//   pulses err for one cycle.
//   Ports:
//     clk   - clock, all state updates on the rising edge
//     reset - synchronous, active-high reset
//     bus   - demux8x8_deframer_if slave modport (stream in, frame out)
module demux8x8_deframer #(
  parameter int WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  demux8x8_deframer_if.slave    bus
);
  localparam int N = 8;

  logic [2:0]       slot_q;
  logic [WIDTH-1:0] fill_q [N-1];
  logic [WIDTH-1:0] out_q  [N];
  logic             o_valid_q;
  logic             err_q;
  logic             i_ready_c;
  logic             acc;
  logic             misaligned;

  // Only closing a frame needs the output buffer, so that is the only
  // slot where backpressure can stall the input.
  assign i_ready_c  = !reset && !((slot_q == 3'd7) && o_valid_q && !bus.o_ready);
  assign acc        = bus.i_valid && i_ready_c;
  assign misaligned = bus.i_sync && (slot_q != 3'd0);

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q    <= 3'd0;
      o_valid_q <= 1'b0;
      err_q     <= 1'b0;
      for (int k = 0; k < N - 1; k++) fill_q[k] <= '0;
      for (int k = 0; k < N; k++) out_q[k] <= '0;
    end else begin
      err_q <= 1'b0;
      // A consumed frame is released unless a new one lands this cycle,
      // in which case the load below overrides this clear.
      if (o_valid_q && bus.o_ready) o_valid_q <= 1'b0;
      if (acc) begin
        if (misaligned) begin
          // Abandon the partial frame; the sync word becomes slot 0.
          fill_q[0] <= bus.i;
          slot_q    <= 3'd1;
          err_q     <= 1'b1;
        end else if (slot_q == 3'd7) begin
          for (int k = 0; k < N - 1; k++) out_q[k] <= fill_q[k];
          out_q[N-1] <= bus.i;
          o_valid_q  <= 1'b1;
          slot_q     <= 3'd0;
        end else begin
          for (int k = 0; k < N - 1; k++) begin
            if (slot_q == 3'(k)) fill_q[k] <= bus.i;
          end
          slot_q <= slot_q + 3'd1;
        end
      end
    end
  end

  assign bus.i_ready = i_ready_c;
  assign bus.o_valid = o_valid_q;
  assign bus.slot    = slot_q;
  assign bus.err     = err_q;
  assign bus.o0      = out_q[0];
  assign bus.o1      = out_q[1];
  assign bus.o2      = out_q[2];
  assign bus.o3      = out_q[3];
  assign bus.o4      = out_q[4];
  assign bus.o5      = out_q[5];
  assign bus.o6      = out_q[6];
  assign bus.o7      = out_q[7];
endmodule

// File: tb/tb_demux8x8_deframer.sv
// tb_demux8x8_deframer
//   Directed bench for demux8x8_deframer. Inputs change 1 time unit after
//   the rising edge; registered outputs are sampled at the same point, and
//   the combinational i_ready is sampled after inputs settle but before the
//   next edge.
module tb_demux8x8_deframer;
  logic clk;
  logic reset;
  int   checks;
  int   failures;

  demux8x8_deframer_if #(.WIDTH(8)) bus ();

  demux8x8_deframer #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Read lane k of the output buffer.
  function automatic logic [7:0] lane(input int k);
    case (k)
      0: return bus.o0;
      1: return bus.o1;
      2: return bus.o2;
      3: return bus.o3;
      4: return bus.o4;
      5: return bus.o5;
      6: return bus.o6;
      default: return bus.o7;
    endcase
  endfunction

  // Present one word and advance one clock.
  task automatic put_word(input logic [7:0] w, input logic sync);
    bus.i       = w;
    bus.i_valid = 1'b1;
    bus.i_sync  = sync;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.i_valid = 1'b0;
    bus.i_sync  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.i_valid = 1'b0;
    bus.i_sync  = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset       = 1'b1;
    bus.i_valid = 1'b1;
    bus.i       = 8'h55;
    @(posedge clk);
    #1;
    checks++;
    if (bus.i_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_i_ready got=%b exp=0", bus.i_ready);
    end
    checks++;
    if (bus.slot !== 3'd0) begin
      failures++;
      $display("[TB] FAIL reset_slot got=%0d exp=0", bus.slot);
    end
    checks++;
    if (bus.o_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_o_valid got=%b exp=0", bus.o_valid);
    end
    checks++;
    if (bus.err !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_err got=%b exp=0", bus.err);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (lane(k) !== 8'h00) begin
        failures++;
        $display("[TB] FAIL reset_lane%0d got=%h exp=00", k, lane(k));
      end
    end
    bus.i_valid = 1'b0;
    reset       = 1'b0;
  endtask

  task automatic test_basic_frame();
    int err_seen;
    err_seen    = 0;
    bus.o_ready = 1'b1;
    for (int w = 0; w < 8; w++) begin
      put_word(8'h10 + 8'(w), w == 0);
      if (bus.err === 1'b1) err_seen++;
    end
    checks++;
    if (bus.o_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL basic_o_valid got=%b exp=1", bus.o_valid);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (lane(k) !== 8'h10 + 8'(k)) begin
        failures++;
        $display("[TB] FAIL basic_lane%0d got=%h exp=%h", k, lane(k), 8'h10 + 8'(k));
      end
    end
    checks++;
    if (bus.slot !== 3'd0) begin
      failures++;
      $display("[TB] FAIL basic_slot got=%0d exp=0", bus.slot);
    end
    checks++;
    if (err_seen != 0) begin
      failures++;
      $display("[TB] FAIL basic_err got=%0d pulses exp=0", err_seen);
    end
    idle();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL basic_consumed got=%b exp=0", bus.o_valid);
    end
    checks++;
    if (bus.o3 !== 8'h13) begin
      failures++;
      $display("[TB] FAIL basic_hold got=%h exp=13", bus.o3);
    end
  endtask

  task automatic test_streaming();
    do_reset();
    bus.o_ready = 1'b1;
    for (int w = 0; w < 16; w++) begin
      bus.i       = 8'(w);
      bus.i_valid = 1'b1;
      bus.i_sync  = (w == 0) || (w == 8);
      #1;
      checks++;
      if (bus.i_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL stream_i_ready word=%0d got=%b exp=1", w, bus.i_ready);
      end
      @(posedge clk);
      #1;
      if (w == 7 || w == 14) begin
        for (int k = 0; k < 8; k++) begin
          checks++;
          if (lane(k) !== 8'(k)) begin
            failures++;
            $display("[TB] FAIL stream_frameA_lane%0d word=%0d got=%h exp=%h", k, w, lane(k), 8'(k));
          end
        end
      end
    end
    checks++;
    if (bus.o_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL stream_frameB_valid got=%b exp=1", bus.o_valid);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (lane(k) !== 8'(k + 8)) begin
        failures++;
        $display("[TB] FAIL stream_frameB_lane%0d got=%h exp=%h", k, lane(k), 8'(k + 8));
      end
    end
    idle();
  endtask

  task automatic test_back_to_back();
    do_reset();
    bus.o_ready = 1'b0;
    for (int w = 0; w < 8; w++) put_word(8'(w), w == 0);
    for (int w = 8; w < 15; w++) begin
      bus.i       = 8'(w);
      bus.i_valid = 1'b1;
      bus.i_sync  = (w == 8);
      #1;
      checks++;
      if (bus.i_ready !== 1'b1) begin
        failures++;
        $display("[TB] FAIL bp_i_ready word=%0d got=%b exp=1", w, bus.i_ready);
      end
      @(posedge clk);
      #1;
    end
    bus.i      = 8'h0F;
    bus.i_sync = 1'b0;
    #1;
    checks++;
    if (bus.i_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_stall got=%b exp=0", bus.i_ready);
    end
    checks++;
    if (bus.slot !== 3'd7) begin
      failures++;
      $display("[TB] FAIL bp_slot got=%0d exp=7", bus.slot);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_held_valid got=%b exp=1", bus.o_valid);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (lane(k) !== 8'(k)) begin
        failures++;
        $display("[TB] FAIL bp_held_lane%0d got=%h exp=%h", k, lane(k), 8'(k));
      end
    end
    bus.o_ready = 1'b1;
    #1;
    checks++;
    if (bus.i_ready !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_release got=%b exp=1", bus.i_ready);
    end
    @(posedge clk);
    #1;
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bp_frameB_valid got=%b exp=1", bus.o_valid);
    end
    checks++;
    if (bus.slot !== 3'd0) begin
      failures++;
      $display("[TB] FAIL bp_frameB_slot got=%0d exp=0", bus.slot);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (lane(k) !== 8'(k + 8)) begin
        failures++;
        $display("[TB] FAIL bp_frameB_lane%0d got=%h exp=%h", k, lane(k), 8'(k + 8));
      end
    end
    idle();
    checks++;
    if (bus.o_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL bp_consumed got=%b exp=0", bus.o_valid);
    end
  endtask

  task automatic test_misalign();
    logic [7:0] words [11];
    int err_count;
    words     = '{8'h20, 8'h21, 8'h22, 8'h30, 8'h31, 8'h32, 8'h33,
                  8'h34, 8'h35, 8'h36, 8'h37};
    err_count = 0;
    do_reset();
    bus.o_ready = 1'b1;
    for (int w = 0; w < 11; w++) begin
      put_word(words[w], (w == 0) || (w == 3));
      if (bus.err === 1'b1) err_count++;
      checks++;
      if (bus.err !== (w == 3)) begin
        failures++;
        $display("[TB] FAIL misalign_err word=%0d got=%b exp=%b", w, bus.err, (w == 3));
      end
      if (w == 3) begin
        checks++;
        if (bus.slot !== 3'd1) begin
          failures++;
          $display("[TB] FAIL misalign_slot got=%0d exp=1", bus.slot);
        end
      end
    end
    checks++;
    if (err_count != 1) begin
      failures++;
      $display("[TB] FAIL misalign_pulses got=%0d exp=1", err_count);
    end
    checks++;
    if (bus.o_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL misalign_valid got=%b exp=1", bus.o_valid);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (lane(k) !== 8'h30 + 8'(k)) begin
        failures++;
        $display("[TB] FAIL misalign_lane%0d got=%h exp=%h", k, lane(k), 8'h30 + 8'(k));
      end
    end
    idle();
  endtask

  task automatic test_bubbles();
    int gaps [8];
    gaps = '{0, 1, 0, 2, 1, 0, 3, 1};
    do_reset();
    bus.o_ready = 1'b1;
    for (int w = 0; w < 8; w++) begin
      for (int g = 0; g < gaps[w]; g++) begin
        idle();
        checks++;
        if (bus.slot !== 3'(w)) begin
          failures++;
          $display("[TB] FAIL bubble_slot word=%0d got=%0d exp=%0d", w, bus.slot, w);
        end
      end
      put_word(8'hA0 + 8'(w), w == 0);
    end
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL bubble_valid got=%b exp=1", bus.o_valid);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (lane(k) !== 8'hA0 + 8'(k)) begin
        failures++;
        $display("[TB] FAIL bubble_lane%0d got=%h exp=%h", k, lane(k), 8'hA0 + 8'(k));
      end
    end
    idle();
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.o_ready = 1'b0;
    for (int w = 0; w < 8; w++) put_word(8'h50 + 8'(w), w == 0);
    for (int w = 0; w < 5; w++) put_word(8'h60 + 8'(w), w == 0);
    checks++;
    if (bus.slot !== 3'd5 || bus.o_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_pre got slot=%0d valid=%b exp slot=5 valid=1", bus.slot, bus.o_valid);
    end
    reset       = 1'b1;
    bus.i_valid = 1'b1;
    bus.i       = 8'h77;
    #1;
    checks++;
    if (bus.i_ready !== 1'b0) begin
      failures++;
      $display("[TB] FAIL rstmid_i_ready got=%b exp=0", bus.i_ready);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.o_valid !== 1'b0 || bus.slot !== 3'd0) begin
      failures++;
      $display("[TB] FAIL rstmid_state got valid=%b slot=%0d exp valid=0 slot=0", bus.o_valid, bus.slot);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (lane(k) !== 8'h00) begin
        failures++;
        $display("[TB] FAIL rstmid_lane%0d got=%h exp=00", k, lane(k));
      end
    end
    reset       = 1'b0;
    bus.o_ready = 1'b1;
    for (int w = 0; w < 8; w++) put_word(8'h40 + 8'(w), w == 0);
    bus.i_valid = 1'b0;
    checks++;
    if (bus.o_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL rstmid_fresh_valid got=%b exp=1", bus.o_valid);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (lane(k) !== 8'h40 + 8'(k)) begin
        failures++;
        $display("[TB] FAIL rstmid_fresh_lane%0d got=%h exp=%h", k, lane(k), 8'h40 + 8'(k));
      end
    end
    idle();
  endtask

  initial begin
    checks      = 0;
    failures    = 0;
    reset       = 1'b1;
    bus.i       = 8'h00;
    bus.i_valid = 1'b0;
    bus.i_sync  = 1'b0;
    bus.o_ready = 1'b0;
    #1;
    test_reset();
    test_basic_frame();
    test_streaming();
    test_back_to_back();
    test_misalign();
    test_bubbles();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
